// File: rtl/dct_mcu_sequencer_pkg.sv
// dct_pkg: types and constants shared by the DCT MCU sequencer and the
// downstream entropy coder.
//   mcu_t      : 8x8 block of 32-bit words, indexed [row][col]
//   MCU_SIZE   : words per MCU
//   ZIGZAG_LUT : JPEG zigzag order, entry k = raster index (row*8+col)
package dct_pkg;

    localparam int MCU_SIZE = 64;

    typedef logic [7:0][7:0][31:0] mcu_t;

    localparam logic [5:0] ZIGZAG_LUT [MCU_SIZE] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage

// File: rtl/dct_mcu_sequencer_if.sv
// Sample/coefficient stream interface of the DCT MCU sequencer.
//   in_valid/in_ready/in_data            : sample stream into the sequencer
//   out_valid/out_ready/out_data/out_last : coefficient stream out
// Modports: master = stream source/sink around the sequencer,
//           slave  = the sequencer itself.
interface dct_mcu_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/dct_mcu_sequencer.sv
// dct_mcu_sequencer: feeds 8x8 MCUs to the combinational DCT+quant datapath
// (instantiated beside this block), waits for the multicycle path to
// settle, captures the 64 coefficients and streams them out. The
// coefficient register lets the next MCU load while the previous drains.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready/in_data sample stream,
//                  out_valid/out_ready/out_data/out_last coefficient stream
//   mcu_o        : MCU buffer driving the datapath input
//   dct_i        : datapath coefficient output
//   busy         : MCU partially loaded, settling or draining
//   blocks_done  : count of fully drained blocks, wraps
//
// Build option: DCT_SEQ_ZIGZAG_EN - when defined, coefficients leave in
// JPEG zigzag order; otherwise in raster order.
//
// Input FSM states:
//   state  | meaning
//   FILL   | accepting samples into mcu_o, in_ready high
//   SETTLE | mcu_o frozen, waiting for datapath settle and a free drain slot
module dct_mcu_sequencer
    import dct_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int BLK_CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dct_mcu_sequencer_if.slave    bus,
    output mcu_t                  mcu_o,
    input  mcu_t                  dct_i,
    output logic                  busy,
    output logic [BLK_CNT_W-1:0]  blocks_done
);

    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [0:0] state;
    logic [5:0] in_cnt;
    logic [3:0] settle_cnt;
    mcu_t       coef;
    logic       out_valid_q;
    logic [5:0] out_cnt;
    logic [5:0] ord_idx;

    logic in_hs;
    logic out_hs;
    logic last_hs;
    logic capture;

    assign in_hs   = bus.in_valid && (state == ST_FILL);
    assign out_hs  = out_valid_q && bus.out_ready;
    assign last_hs = out_hs && (out_cnt == 6'd63);

    // A settled MCU may only move into the coefficient register when the
    // register is empty or is being emptied by its final handshake now.
    assign capture = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST) &&
                     (!out_valid_q || last_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FILL;
            in_cnt     <= 6'd0;
            settle_cnt <= 4'd0;
            mcu_o      <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (in_hs) begin
                        mcu_o[in_cnt[5:3]][in_cnt[2:0]] <= bus.in_data;
                        if (in_cnt == 6'd63) begin
                            in_cnt     <= 6'd0;
                            settle_cnt <= 4'd0;
                            state      <= ST_SETTLE;
                        end else begin
                            in_cnt <= in_cnt + 6'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                    if (capture) begin
                        state <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_cnt     <= 6'd0;
            coef        <= '0;
            blocks_done <= '0;
        end else begin
            if (capture) begin
                coef        <= dct_i;
                out_valid_q <= 1'b1;
                out_cnt     <= 6'd0;
            end else if (out_hs) begin
                out_cnt <= out_cnt + 6'd1;
                if (last_hs) begin
                    out_valid_q <= 1'b0;
                end
            end
            if (last_hs) begin
                blocks_done <= blocks_done + BLK_CNT_W'(1);
            end
        end
    end

`ifdef DCT_SEQ_ZIGZAG_EN
    assign ord_idx = ZIGZAG_LUT[out_cnt];
`else
    assign ord_idx = out_cnt;
`endif

    assign bus.in_ready  = (state == ST_FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = coef[ord_idx[5:3]][ord_idx[2:0]];
    assign bus.out_last  = out_valid_q && (out_cnt == 6'd63);
    assign busy          = (in_cnt != 6'd0) || (state == ST_SETTLE) || out_valid_q;

endmodule

// File: tb/tb_dct_mcu_sequencer.sv
// Bench for dct_mcu_sequencer with an identity datapath stub (dct_i = mcu_o).
// Input handshakes are collected into a reference block; each completed
// block pushes its expected output order onto a queue that is popped on
// every output handshake.
module tb_dct_mcu_sequencer;
    import dct_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    mcu_t        mcu_o;
    mcu_t        dct_i;
    logic        busy;
    logic [15:0] blocks_done;

    dct_mcu_sequencer_if bus ();

    assign dct_i = mcu_o;

    dct_mcu_sequencer #(
        .SETTLE_CYCLES (2),
        .BLK_CNT_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mcu_o       (mcu_o),
        .dct_i       (dct_i),
        .busy        (busy),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int base;
        int nblk;
        int rmode;
        int exp_done;
    } scen_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] blk_buf[64];
    int          zz[64];
    int          in_idx = 0;
    int          blk_pos = 0;
    int          cyc = 0;
    int          last_in_cyc = 0;
    int          last_rise_cyc = 0;
    int          rise_cnt = 0;
    int          blocks_pushed = 0;
    int          ov_drops = 0;
    int          ready_mode = 0;
    bit          bp_mode = 0;
    bit          prev_stall = 0;
    bit          prev_ov = 0;
    logic [31:0] prev_data = '0;
    logic        in_ready_at_rise = 1'b0;

    task automatic check(input bit ok, input string nm, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ord_tb(input int k);
`ifdef DCT_SEQ_ZIGZAG_EN
        return zz[k];
`else
        return k;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = always high, 1 = random, 2 = held low
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_idx     = 0;
            blk_pos    = 0;
            prev_stall = 0;
            prev_ov    = 0;
        end else begin
            if (prev_stall) begin
                check(bus.out_valid == 1'b1, "stall_valid", bus.out_valid, 1);
                check(bus.out_data == prev_data, "stall_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && !prev_ov) begin
                last_rise_cyc    = cyc;
                in_ready_at_rise = bus.in_ready;
                rise_cnt++;
            end
            if (bp_mode && prev_ov && !bus.out_valid && exp_q.size() != 0) ov_drops++;
            if (bus.in_valid && bus.in_ready) begin
                blk_buf[in_idx] = bus.in_data;
                if (in_idx == 63) begin
                    for (int k = 0; k < 64; k++) exp_q.push_back(blk_buf[ord_tb(k)]);
                    last_in_cyc = cyc;
                    blocks_pushed++;
                    in_idx = 0;
                end else begin
                    in_idx++;
                end
            end
            if (bus.out_valid) begin
                check(bus.out_last == (blk_pos == 63), "out_last", bus.out_last, (blk_pos == 63));
            end else begin
                check(bus.out_last == 1'b0, "out_last_idle", bus.out_last, 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", bus.out_data, 0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check(bus.out_data == e, "out_data", bus.out_data, e);
                end
                blk_pos = (blk_pos + 1) % 64;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_ov    = bus.out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_word(input logic [31:0] d);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 5000) begin
                check(1'b0, "in_ready_timeout", guard, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_mcu(input int base);
        for (int i = 0; i < 64; i++) send_word(32'(base + i));
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check(1'b0, "idle_timeout", guard, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int r0);
        int guard = 0;
        while (rise_cnt <= r0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check(1'b0, "out_valid_timeout", guard, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    scen_t scen[3];

    initial begin
        int k;
        int r0;
        int bp0;
        int guard;

        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
            end
        end

        scen[0] = '{base: 1000, nblk: 1, rmode: 0, exp_done: 5};
        scen[1] = '{base: 2000, nblk: 4, rmode: 1, exp_done: 9};
        scen[2] = '{base: 3000, nblk: 2, rmode: 0, exp_done: 11};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
        check(bus.in_ready == 1'b1, "rst_in_ready", bus.in_ready, 1);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(blocks_done == 16'd0, "rst_blocks_done", blocks_done, 0);
        check(mcu_o == '0, "rst_mcu_o", mcu_o[0][0], 0);
        @(posedge clk);
        #1;

        // reset after 30 input beats
        for (int i = 0; i < 30; i++) send_word(32'(200 + i));
        pulse_reset();
        @(negedge clk);
        check(bus.out_valid == 1'b0, "rst1_out_valid", bus.out_valid, 0);
        check(busy == 1'b0, "rst1_busy", busy, 0);
        check(blocks_done == 16'd0, "rst1_blocks_done", blocks_done, 0);
        check(bus.in_ready == 1'b1, "rst1_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // reset mid-drain
        send_mcu(300);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus.out_valid && blk_pos == 20) && guard < 2000);
        if (guard >= 2000) check(1'b0, "middrain_timeout", guard, 0);
        @(posedge clk);
        #1;
        pulse_reset();
        @(negedge clk);
        check(bus.out_valid == 1'b0, "rst2_out_valid", bus.out_valid, 0);
        check(busy == 1'b0, "rst2_busy", busy, 0);
        check(blocks_done == 16'd0, "rst2_blocks_done", blocks_done, 0);
        @(posedge clk);
        #1;
        send_mcu(700);
        wait_idle();
        check(blocks_done == 16'd1, "fresh_blocks_done", blocks_done, 1);

        // latency from last input handshake to first out_valid
        r0 = rise_cnt;
        send_mcu(0);
        wait_rise(r0);
        check(last_rise_cyc - last_in_cyc == 3, "latency", last_rise_cyc - last_in_cyc, 3);
        check(in_ready_at_rise == 1'b1, "latency_in_ready", in_ready_at_rise, 1);
        wait_idle();
        check(blocks_done == 16'd2, "latency_blocks_done", blocks_done, 2);

        // back-to-back MCUs with output held off
        ready_mode = 2;
        r0 = rise_cnt;
        bp0 = blocks_pushed;
        ov_drops = 0;
        bp_mode = 1;
        fork
            begin
                send_mcu(0);
                send_mcu(100);
            end
            begin
                wait_rise(r0);
                repeat (80) @(posedge clk);
            end
        join
        @(negedge clk);
        check(bus.in_ready == 1'b0, "bp_in_ready", bus.in_ready, 0);
        check(blocks_pushed - bp0 == 2, "bp_loaded", blocks_pushed - bp0, 2);
        check(bus.out_valid == 1'b1, "bp_out_valid", bus.out_valid, 1);
        ready_mode = 0;
        @(posedge clk);
        #1;
        wait_idle();
        check(ov_drops == 0, "bp_ov_drops", ov_drops, 0);
        check(blocks_done == 16'd4, "bp_blocks_done", blocks_done, 4);
        bp_mode = 0;

        for (int i = 0; i < 3; i++) begin
            ready_mode = scen[i].rmode;
            for (int b = 0; b < scen[i].nblk; b++) send_mcu(scen[i].base + b * 64);
            wait_idle();
            check(blocks_done == 16'(scen[i].exp_done), "scen_blocks_done", blocks_done, scen[i].exp_done);
            ready_mode = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
